mem_stage_access_unit: RTL and testbench
========================================

// Module: mem_stage_access_unit
// PURPOSE
// MEM-stage data-memory access unit, directly downstream of the EX/MEM pipeline register. Consumes its
// Size/Enable/rw/Load controls plus address and store data, runs one req/ack transaction on a
// variable-latency data memory, and steers byte/word lanes (big-endian). Returns load data and
// holds the pipeline with Stall_Out while the access is outstanding.
// PARAMETERS
// TIMEOUT  16  REQ cycles without Mem_Ack before the access aborts with a fault (>=2)
// ADDR_W   32  address width; data path fixed at 32 bits
// PORTS
// CLK            in   1       clock, all state on posedge
// CLR            in   1       reset, synchronous, active-low (CLR=0 resets)
// Enable_In      in   1       memory op present this cycle
// rw_In          in   1       1=write, 0=read
// Size_In        in   1       1=word, 0=byte
// Load_In        in   1       read result is destined for the register file
// Addr_In        in   ADDR_W  byte address
// Data_In        in   32      store data (byte in [7:0])
// Mem_Req        out  1       request valid, held until Mem_Ack or abort
// Mem_We         out  1       write strobe qualifying Mem_Req
// Mem_Addr       out  ADDR_W  word-aligned address (Addr_In with [1:0]=00)
// Mem_ByteEn     out  4       lane enables, bit3=bits[31:24]
// Mem_WData      out  32      store data, byte replicated on all lanes
// Mem_Ack        in   1       completes the transaction; Mem_RData valid same cycle
// Mem_RData      in   32      read data
// Load_Data_Out  out  32      zero-extended load result
// Load_Valid_Out out  1       one-cycle pulse: load result valid
// Stall_Out      out  1       freeze upstream stages (combinational)
// Fault_Out      out  1       one-cycle pulse: misaligned access or timeout
// BEHAVIOUR
// - Reset (CLR=0 at edge): state IDLE, timeout counter 0, all registered outputs 0. Mid-transaction
//   reset abandons the access; Mem_Req low the following cycle; late Mem_Ack ignored.
// - States: IDLE -> REQ -> DONE -> IDLE. DONE always returns to IDLE; inputs ignored in DONE.
// - IDLE: Enable_In=1 and aligned -> latch op and lane controls, go REQ. Word with Addr_In[1:0]!=0
//   -> no request, no stall, Fault_Out=1 next cycle, stay IDLE. Enable_In=0 -> stay IDLE.
// - REQ: Mem_Req=1; Mem_We/Addr/ByteEn/WData registered, stable throughout. Mem_Ack=1 -> capture
//   lane-extracted read data, go DONE. Counter reaches TIMEOUT-1 without ack -> Fault_Out pulse,
//   go DONE with Load_Valid_Out suppressed.
// - DONE: Mem_Req=0; Load_Valid_Out=1 iff read && Load && no fault; Load_Data_Out holds value until
//   next capture.
// - Stall_Out = (IDLE && Enable_In && aligned) || REQ. Zero in DONE, so upstream advances at DONE's
//   edge. Minimum access: 3 cycles (IDLE accept, REQ+ack, DONE), Stall_Out high 2 cycles.
// - Lanes (big-endian): Addr[1:0]=00->[31:24]/ByteEn 1000, 01->[23:16]/0100,
//   10->[15:8]/0010, 11->[7:0]/0001. Word: ByteEn 1111, data unchanged.
// - Byte read: selected lane zero-extended to 32 bits. Writes never assert Load_Valid_Out.
// - Mem_Ack outside REQ ignored. Counter clears on REQ entry; width clog2(TIMEOUT).
// STRUCTURE
// - mem_access_pkg: state encoding (IDLE/REQ/DONE), SIZE_BYTE/SIZE_WORD, RW_READ/RW_WRITE
//   constants, lane-index-to-ByteEn function.
// - Sub-module mem_byte_lane: combinational store replication, ByteEn generation, load lane
//   extraction and zero-extend; top holds FSM, counter, output registers.
// TESTING
// 1. Word read 0x10, ack after 2 REQ cycles, RData 0xDEADBEEF -> Load_Data 0xDEADBEEF, Valid 1 cycle, Stall 3 cycles.
// 2. Byte write 0x13, Data_In 0xA5 -> Mem_Addr 0x10, ByteEn 0001, WData 0xA5A5A5A5, We=1, no Valid.
// 3. Byte read 0x11, RData 0x11223344 -> Load_Data_Out 0x00000022, ByteEn 0100.
// 4. Word read 0x12 -> Fault_Out 1 cycle, Mem_Req and Stall_Out stay 0.
// 5. TIMEOUT=4, no ack -> Fault after 4 REQ cycles, Mem_Req drops, Stall releases, no Valid.
// 6. CLR=0 during REQ -> next cycle all outputs 0, IDLE; subsequent Mem_Ack has no effect.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit: FSM states,
// size/direction constants and the big-endian lane-to-byte-enable mapping.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  // Lane 0 is the most significant byte (big-endian), so it maps to ByteEn bit 3.
  function automatic logic [3:0] lane_byte_en(input logic [1:0] lane);
    return 4'b1000 >> lane;
  endfunction

endpackage

// File: rtl/mem_stage_access_unit_if.sv
// Request/acknowledge bus between the access unit (master) and the
// variable-latency data memory (slave).
interface mem_stage_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              Mem_Req;
  logic              Mem_We;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [3:0]        Mem_ByteEn;
  logic [31:0]       Mem_WData;
  logic              Mem_Ack;
  logic [31:0]       Mem_RData;

  modport master (
    output Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn, Mem_WData,
    input  Mem_Ack, Mem_RData
  );

  modport slave (
    input  Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn, Mem_WData,
    output Mem_Ack, Mem_RData
  );
endinterface

// File: rtl/mem_byte_lane.sv
// Combinational lane steering: store-byte replication and byte enables on the
// way out, big-endian lane extraction with zero-extension on the way back.
module mem_byte_lane
  import mem_access_pkg::*;
(
  input  logic        st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_byte_en,
  output logic [31:0] st_wdata,
  input  logic        ld_size,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0] ld_byte;

  assign st_byte_en = (st_size == SIZE_BYTE) ? lane_byte_en(st_lane) : 4'b1111;
  assign st_wdata   = (st_size == SIZE_BYTE) ? {4{st_data[7:0]}} : st_data;

  // NOTE: ld_byte gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    ld_byte = 8'h00;
    case (ld_lane)
      2'd0: ld_byte = ld_rdata[31:24];
      2'd1: ld_byte = ld_rdata[23:16];
      2'd2: ld_byte = ld_rdata[15:8];
      2'd3: ld_byte = ld_rdata[7:0];
      default: ld_byte = 8'h00;
    endcase
  end

  assign ld_data = (ld_size == SIZE_BYTE) ? {24'h0, ld_byte} : ld_rdata;

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage access unit: accepts one op from EX/MEM, runs a single req/ack
// transaction with timeout, and returns load data while stalling upstream.
module mem_stage_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    Enable_In,
  input  logic                    rw_In,
  input  logic                    Size_In,
  input  logic                    Load_In,
  input  logic [ADDR_W-1:0]       Addr_In,
  input  logic [31:0]             Data_In,
  mem_stage_access_unit_if.master mem,
  output logic [31:0]             Load_Data_Out,
  output logic                    Load_Valid_Out,
  output logic                    Stall_Out,
  output logic                    Fault_Out
);

  localparam int                CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              op_rw, op_load, op_size;
  logic [1:0]        op_lane;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;
  logic              misaligned, accept, timed_out;
  logic [3:0]        st_byte_en;
  logic [31:0]       st_wdata, ld_data;

  assign misaligned = (Size_In == SIZE_WORD) && (Addr_In[1:0] != 2'b00);
  assign accept     = Enable_In && !misaligned;
  assign timed_out  = (cnt == LAST) && !mem.Mem_Ack;

  mem_byte_lane u_lane (
    .st_size    (Size_In),
    .st_lane    (Addr_In[1:0]),
    .st_data    (Data_In),
    .st_byte_en (st_byte_en),
    .st_wdata   (st_wdata),
    .ld_size    (op_size),
    .ld_lane    (op_lane),
    .ld_rdata   (mem.Mem_RData),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = ST_REQ;
      ST_REQ:  if (mem.Mem_Ack || timed_out) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Stall drops in DONE so the upstream stage advances on DONE's closing edge.
  assign Stall_Out      = ((state == ST_IDLE) && accept) || (state == ST_REQ);
  assign mem.Mem_Req    = (state == ST_REQ);
  assign mem.Mem_We     = req_we;
  assign mem.Mem_Addr   = req_addr;
  assign mem.Mem_ByteEn = req_be;
  assign mem.Mem_WData  = req_wdata;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      op_rw          <= 1'b0;
      op_load        <= 1'b0;
      op_size        <= 1'b0;
      op_lane        <= 2'b00;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_be         <= 4'b0000;
      req_wdata      <= 32'h0;
      Load_Data_Out  <= 32'h0;
      Load_Valid_Out <= 1'b0;
      Fault_Out      <= 1'b0;
    end else begin
      state          <= state_n;
      Load_Valid_Out <= 1'b0;
      Fault_Out      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt       <= '0;
            op_rw     <= rw_In;
            op_load   <= Load_In;
            op_size   <= Size_In;
            op_lane   <= Addr_In[1:0];
            req_we    <= (rw_In == RW_WRITE);
            req_addr  <= {Addr_In[ADDR_W-1:2], 2'b00};
            req_be    <= st_byte_en;
            req_wdata <= st_wdata;
          end else if (Enable_In) begin
            Fault_Out <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem.Mem_Ack) begin
            Load_Data_Out  <= ld_data;
            Load_Valid_Out <= (op_rw == RW_READ) && op_load;
          end else if (timed_out) begin
            Fault_Out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed bench for mem_stage_access_unit (TIMEOUT=4): word/byte access,
// lane steering, misalignment fault, timeout and mid-transaction reset.
module tb_mem_stage_access_unit;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        Enable_In, rw_In, Size_In, Load_In;
  logic [31:0] Addr_In, Data_In;
  logic [31:0] Load_Data_Out;
  logic        Load_Valid_Out, Stall_Out, Fault_Out;
  int          errors = 0;
  int          checks = 0;

  mem_stage_access_unit_if #(.ADDR_W(32)) bus ();

  mem_stage_access_unit #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .CLK            (CLK),
    .CLR            (CLR),
    .Enable_In      (Enable_In),
    .rw_In          (rw_In),
    .Size_In        (Size_In),
    .Load_In        (Load_In),
    .Addr_In        (Addr_In),
    .Data_In        (Data_In),
    .mem            (bus.master),
    .Load_Data_Out  (Load_Data_Out),
    .Load_Valid_Out (Load_Valid_Out),
    .Stall_Out      (Stall_Out),
    .Fault_Out      (Fault_Out)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_op(input logic en, input logic rw, input logic size,
                          input logic load, input logic [31:0] addr, input logic [31:0] data);
    Enable_In = en; rw_In = rw; Size_In = size; Load_In = load;
    Addr_In = addr; Data_In = data;
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    drive_op(0, 0, 0, 0, 32'h0, 32'h0);
    bus.Mem_Ack = 1'b0; bus.Mem_RData = 32'h0;
    cyc(); cyc();
    checks++;
    if ({bus.Mem_Req, bus.Mem_We, Load_Valid_Out, Stall_Out, Fault_Out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got req/we/valid/stall/fault=%b exp 00000",
               {bus.Mem_Req, bus.Mem_We, Load_Valid_Out, Stall_Out, Fault_Out});
    end
    checks++;
    if ({bus.Mem_Addr, bus.Mem_ByteEn, bus.Mem_WData, Load_Data_Out} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data got addr=%h be=%b wdata=%h ld=%h exp all zero",
               bus.Mem_Addr, bus.Mem_ByteEn, bus.Mem_WData, Load_Data_Out);
    end
    CLR = 1'b1;
    cyc();
  endtask

  task automatic test_word_read();
    int stall_cycles = 0;
    drive_op(1, 0, 1, 1, 32'h10, 32'h0);
    if (Stall_Out) stall_cycles++;
    cyc();
    drive_op(0, 0, 0, 0, 32'h0, 32'h0);
    checks++;
    if (bus.Mem_Req !== 1'b1 || bus.Mem_Addr !== 32'h10 || bus.Mem_ByteEn !== 4'b1111 || bus.Mem_We !== 1'b0) begin
      errors++;
      $display("FAIL wr_req got req=%b addr=%h be=%b we=%b exp 1 00000010 1111 0",
               bus.Mem_Req, bus.Mem_Addr, bus.Mem_ByteEn, bus.Mem_We);
    end
    if (Stall_Out) stall_cycles++;
    cyc();
    bus.Mem_Ack = 1'b1; bus.Mem_RData = 32'hDEADBEEF;
    #1;
    if (Stall_Out) stall_cycles++;
    cyc();
    bus.Mem_Ack = 1'b0; bus.Mem_RData = 32'h0;
    #1;
    if (Stall_Out) stall_cycles++;
    checks++;
    if (Load_Valid_Out !== 1'b1 || Load_Data_Out !== 32'hDEADBEEF || bus.Mem_Req !== 1'b0) begin
      errors++;
      $display("FAIL wr_done got valid=%b data=%h req=%b exp 1 deadbeef 0",
               Load_Valid_Out, Load_Data_Out, bus.Mem_Req);
    end
    cyc();
    checks++;
    if (Load_Valid_Out !== 1'b0 || Load_Data_Out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_hold got valid=%b data=%h exp 0 deadbeef", Load_Valid_Out, Load_Data_Out);
    end
    checks++;
    if (stall_cycles != 3) begin
      errors++;
      $display("FAIL wr_stall got %0d stall cycles exp 3", stall_cycles);
    end
  endtask

  task automatic test_byte_write();
    drive_op(1, 1, 0, 0, 32'h13, 32'h123456A5);
    cyc();
    drive_op(0, 0, 0, 0, 32'h0, 32'h0);
    checks++;
    if (bus.Mem_Req !== 1'b1 || bus.Mem_We !== 1'b1 || bus.Mem_Addr !== 32'h10 ||
        bus.Mem_ByteEn !== 4'b0001 || bus.Mem_WData !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bw_req got req=%b we=%b addr=%h be=%b wdata=%h exp 1 1 00000010 0001 a5a5a5a5",
               bus.Mem_Req, bus.Mem_We, bus.Mem_Addr, bus.Mem_ByteEn, bus.Mem_WData);
    end
    bus.Mem_Ack = 1'b1; bus.Mem_RData = 32'hCAFEF00D;
    cyc();
    bus.Mem_Ack = 1'b0;
    #1;
    checks++;
    if (Load_Valid_Out !== 1'b0 || Stall_Out !== 1'b0) begin
      errors++;
      $display("FAIL bw_done got valid=%b stall=%b exp 0 0", Load_Valid_Out, Stall_Out);
    end
    cyc();
  endtask

  task automatic test_byte_lanes();
    logic [3:0]  exp_be[4]   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [31:0] exp_data[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      drive_op(1, 0, 0, 1, 32'h40 + i, 32'h0);
      cyc();
      drive_op(0, 0, 0, 0, 32'h0, 32'h0);
      checks++;
      if (bus.Mem_ByteEn !== exp_be[i] || bus.Mem_Addr !== 32'h40) begin
        errors++;
        $display("FAIL lane%0d_req got be=%b addr=%h exp %b 00000040",
                 i, bus.Mem_ByteEn, bus.Mem_Addr, exp_be[i]);
      end
      bus.Mem_Ack = 1'b1; bus.Mem_RData = 32'h11223344;
      cyc();
      bus.Mem_Ack = 1'b0;
      #1;
      checks++;
      if (Load_Valid_Out !== 1'b1 || Load_Data_Out !== exp_data[i]) begin
        errors++;
        $display("FAIL lane%0d_load got valid=%b data=%h exp 1 %h",
                 i, Load_Valid_Out, Load_Data_Out, exp_data[i]);
      end
      cyc();
    end
    // Read without Load: data still captured, valid suppressed.
    drive_op(1, 0, 0, 0, 32'h14, 32'h0);
    cyc();
    drive_op(0, 0, 0, 0, 32'h0, 32'h0);
    bus.Mem_Ack = 1'b1; bus.Mem_RData = 32'hAABBCCDD;
    cyc();
    bus.Mem_Ack = 1'b0;
    #1;
    checks++;
    if (Load_Valid_Out !== 1'b0 || Load_Data_Out !== 32'h000000AA) begin
      errors++;
      $display("FAIL noload got valid=%b data=%h exp 0 000000aa", Load_Valid_Out, Load_Data_Out);
    end
    cyc();
  endtask

  task automatic test_misaligned();
    drive_op(1, 0, 1, 1, 32'h12, 32'h0);
    checks++;
    if (Stall_Out !== 1'b0) begin
      errors++;
      $display("FAIL mis_stall got %b exp 0", Stall_Out);
    end
    cyc();
    checks++;
    if (Fault_Out !== 1'b1 || bus.Mem_Req !== 1'b0 || Stall_Out !== 1'b0) begin
      errors++;
      $display("FAIL mis_fault got fault=%b req=%b stall=%b exp 1 0 0", Fault_Out, bus.Mem_Req, Stall_Out);
    end
    drive_op(0, 0, 0, 0, 32'h0, 32'h0);
    cyc();
    checks++;
    if (Fault_Out !== 1'b0 || bus.Mem_Req !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse got fault=%b req=%b exp 0 0", Fault_Out, bus.Mem_Req);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    drive_op(1, 0, 1, 1, 32'h20, 32'h0);
    cyc();
    drive_op(0, 0, 0, 0, 32'h0, 32'h0);
    while (bus.Mem_Req === 1'b1 && req_cycles < 20) begin
      req_cycles++;
      cyc();
    end
    checks++;
    if (req_cycles != 4) begin
      errors++;
      $display("FAIL to_len got %0d REQ cycles exp 4", req_cycles);
    end
    checks++;
    if (Fault_Out !== 1'b1 || Load_Valid_Out !== 1'b0 || Stall_Out !== 1'b0 || bus.Mem_Req !== 1'b0) begin
      errors++;
      $display("FAIL to_fault got fault=%b valid=%b stall=%b req=%b exp 1 0 0 0",
               Fault_Out, Load_Valid_Out, Stall_Out, bus.Mem_Req);
    end
    cyc();
    checks++;
    if (Fault_Out !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse got fault=%b exp 0", Fault_Out);
    end
  endtask

  task automatic test_reset_mid_req();
    drive_op(1, 1, 1, 0, 32'h30, 32'h87654321);
    cyc();
    drive_op(0, 0, 0, 0, 32'h0, 32'h0);
    checks++;
    if (bus.Mem_Req !== 1'b1 || bus.Mem_WData !== 32'h87654321) begin
      errors++;
      $display("FAIL rst_pre got req=%b wdata=%h exp 1 87654321", bus.Mem_Req, bus.Mem_WData);
    end
    CLR = 1'b0;
    cyc();
    CLR = 1'b1;
    #1;
    checks++;
    if ({bus.Mem_Req, bus.Mem_We, Load_Valid_Out, Stall_Out, Fault_Out} !== 5'b0 ||
        {bus.Mem_Addr, bus.Mem_ByteEn, bus.Mem_WData, Load_Data_Out} !== 100'h0) begin
      errors++;
      $display("FAIL rst_mid got req=%b we=%b addr=%h be=%b wdata=%h ld=%h exp all zero",
               bus.Mem_Req, bus.Mem_We, bus.Mem_Addr, bus.Mem_ByteEn, bus.Mem_WData, Load_Data_Out);
    end
    bus.Mem_Ack = 1'b1; bus.Mem_RData = 32'hFFFFFFFF;
    cyc();
    bus.Mem_Ack = 1'b0;
    cyc();
    checks++;
    if (Load_Valid_Out !== 1'b0 || Load_Data_Out !== 32'h0 || bus.Mem_Req !== 1'b0 || Stall_Out !== 1'b0) begin
      errors++;
      $display("FAIL late_ack got valid=%b data=%h req=%b stall=%b exp 0 0 0 0",
               Load_Valid_Out, Load_Data_Out, bus.Mem_Req, Stall_Out);
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_byte_lanes();
    test_misaligned();
    test_timeout();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
